// File: rtl/fa_serial_sched.sv
// Serial add scheduler: two requesters share one external 1-bit full-adder
// cell. A round-robin arbiter picks a request, operands are streamed through
// the cell LSB-first one bit per clock, and the result is returned on a
// valid/ready response port.
//
// state | meaning
// IDLE  | waiting for a request; reqN_ready driven from the arbiter
// RUN   | streaming operand bits through the FA cell, WIDTH cycles
// DONE  | result presented on rsp_*, held until rsp_ready
module fa_serial_sched #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_cin,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_cin,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_sum,
   input  logic             fa_carry,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_sum,
   output logic             rsp_cout,
   output logic             rsp_id,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             id_q, id_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic grant0, grant1;
   logic in_idle, in_run, in_done;

   assign in_idle = (state_q == S_IDLE);
   assign in_run  = (state_q == S_RUN);
   assign in_done = (state_q == S_DONE);

   // Round-robin grant: a lone requester wins; on a tie the one not served last wins
   always_comb begin
      grant0 = req0_valid & (~req1_valid | last_grant_q);
      grant1 = req1_valid & (~req0_valid | ~last_grant_q);
   end

   // Ready is masked during reset so no request appears accepted on a reset edge
   assign req0_ready = in_idle & ~rst & grant0;
   assign req1_ready = in_idle & ~rst & grant1;

   assign fa_a   = in_run & op_a_q[0];
   assign fa_b   = in_run & op_b_q[0];
   assign fa_cin = in_run & carry_q;

   assign rsp_valid = in_done;
   assign rsp_sum   = in_done ? sum_q : '0;
   assign rsp_cout  = in_done & carry_q;
   assign rsp_id    = in_done & id_q;
   assign busy      = in_run | in_done;

   // Next-state and datapath: load on accept, shift one bit per RUN cycle
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      sum_d        = sum_q;
      carry_d      = carry_q;
      id_d         = id_q;
      cnt_d        = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (req0_ready | req1_ready) begin
               op_a_d       = req1_ready ? req1_a   : req0_a;
               op_b_d       = req1_ready ? req1_b   : req0_b;
               carry_d      = req1_ready ? req1_cin : req0_cin;
               id_d         = req1_ready;
               last_grant_d = req1_ready;
               cnt_d        = '0;
               sum_d        = '0;
               state_d      = S_RUN;
            end
         end
         S_RUN: begin
            // sum bits enter at the MSB so after WIDTH shifts bit 0 lands at index 0
            for (int i = 0; i < WIDTH - 1; i++) begin
               sum_d[i] = sum_q[i+1];
            end
            sum_d[WIDTH-1] = fa_sum;
            carry_d        = fa_carry;
            op_a_d         = op_a_q >> 1;
            op_b_d         = op_b_q >> 1;
            cnt_d          = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers with synchronous reset; tie-break favours req0 after reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         op_a_q       <= '0;
         op_b_q       <= '0;
         sum_q        <= '0;
         carry_q      <= 1'b0;
         id_q         <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         sum_q        <= sum_d;
         carry_q      <= carry_d;
         id_q         <= id_d;
         cnt_q        <= cnt_d;
      end
   end

endmodule

// File: tb/tb_fa_serial_sched.sv
// Bench for fa_serial_sched: a WIDTH=8 instance checked by a negedge
// scoreboard monitor plus directed steps, and a WIDTH=1 instance driven
// op-by-op. Both use a behavioural full adder.
module tb_fa_serial_sched;

   localparam int W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         req0_valid, req0_ready, req0_cin;
   logic         req1_valid, req1_ready, req1_cin;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         fa_a, fa_b, fa_cin, fa_sum, fa_carry;
   logic         rsp_valid, rsp_ready, rsp_cout, rsp_id, busy;
   logic [W-1:0] rsp_sum;

   assign fa_sum   = fa_a ^ fa_b ^ fa_cin;
   assign fa_carry = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

   fa_serial_sched #(.WIDTH(W)) u_dut8 (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
      .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_sum(fa_sum), .fa_carry(fa_carry),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
      .rsp_id(rsp_id), .busy(busy)
   );

   logic s_req0_valid, s_req0_ready, s_req0_a, s_req0_b, s_req0_cin;
   logic s_req1_valid, s_req1_ready, s_req1_a, s_req1_b, s_req1_cin;
   logic s_fa_a, s_fa_b, s_fa_cin, s_fa_sum, s_fa_carry;
   logic s_rsp_valid, s_rsp_ready, s_rsp_sum, s_rsp_cout, s_rsp_id, s_busy;

   assign s_fa_sum   = s_fa_a ^ s_fa_b ^ s_fa_cin;
   assign s_fa_carry = (s_fa_a & s_fa_b) | (s_fa_a & s_fa_cin) | (s_fa_b & s_fa_cin);

   fa_serial_sched #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .req0_valid(s_req0_valid), .req0_ready(s_req0_ready), .req0_a(s_req0_a), .req0_b(s_req0_b), .req0_cin(s_req0_cin),
      .req1_valid(s_req1_valid), .req1_ready(s_req1_ready), .req1_a(s_req1_a), .req1_b(s_req1_b), .req1_cin(s_req1_cin),
      .fa_a(s_fa_a), .fa_b(s_fa_b), .fa_cin(s_fa_cin), .fa_sum(s_fa_sum), .fa_carry(s_fa_carry),
      .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_sum(s_rsp_sum), .rsp_cout(s_rsp_cout),
      .rsp_id(s_rsp_id), .busy(s_busy)
   );

   typedef struct packed {
      logic         id;
      logic         cout;
      logic [W-1:0] sum;
   } exp_t;

   typedef struct packed {
      logic id;
      logic cout;
      logic sum;
   } exp1_t;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int n_rsp = 0;

   exp_t  sb[$];
   exp1_t sb1[$];
   bit    grants[$];

   logic         m_act = 1'b0;
   int           m_bit;
   int           acc_cyc;
   logic [W-1:0] m_a, m_b;
   logic         m_c;
   logic [W-1:0] last_sum;
   logic         last_cout, last_id;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model8(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      logic [W:0] s;
      s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      return '{id: id, cout: s[W], sum: s[W-1:0]};
   endfunction

   // Scoreboard monitor for the WIDTH=8 instance, sampled mid-cycle
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         sb.delete();
         m_act = 1'b0;
      end else begin
         chk("ready_onehot", {31'b0, req0_ready & req1_ready}, 0);
         if (m_act && m_bit < W) begin
            chk("fa_a_lsb_first", fa_a, m_a[m_bit]);
            chk("fa_b_lsb_first", fa_b, m_b[m_bit]);
            chk("fa_cin", fa_cin, m_c);
            chk("run_busy", busy, 1);
            chk("run_rsp_valid", rsp_valid, 0);
            m_c = (m_a[m_bit] & m_b[m_bit]) | (m_a[m_bit] & m_c) | (m_b[m_bit] & m_c);
            m_bit++;
         end else if (m_act) begin
            if (m_bit == W) begin
               chk("latency", cyc - acc_cyc, W + 1);
               m_bit++;
            end
            chk("done_valid", rsp_valid, 1);
            chk("done_busy", busy, 1);
            chk("done_fa_zero", {fa_a, fa_b, fa_cin}, 0);
            chk("done_ready_zero", {req0_ready, req1_ready}, 0);
            chk("sb_nonempty", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
               chk("rsp_sum", rsp_sum, sb[0].sum);
               chk("rsp_cout", rsp_cout, sb[0].cout);
               chk("rsp_id", rsp_id, sb[0].id);
               if (rsp_valid && rsp_ready) begin
                  last_sum  = rsp_sum;
                  last_cout = rsp_cout;
                  last_id   = rsp_id;
                  void'(sb.pop_front());
                  n_rsp++;
                  m_act = 1'b0;
               end
            end
         end else begin
            chk("idle_busy", busy, 0);
            chk("idle_rsp_zero", {rsp_valid, rsp_cout, rsp_id, rsp_sum}, 0);
            chk("idle_fa_zero", {fa_a, fa_b, fa_cin}, 0);
            if (req0_ready || req1_ready) begin
               m_a     = req1_ready ? req1_a : req0_a;
               m_b     = req1_ready ? req1_b : req0_b;
               m_c     = req1_ready ? req1_cin : req0_cin;
               sb.push_back(model8(req1_ready, m_a, m_b, m_c));
               grants.push_back(req1_ready);
               m_bit   = 0;
               acc_cyc = cyc;
               m_act   = 1'b1;
            end
         end
      end
   end

   task automatic issue(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      bit got;
      got = 1'b0;
      if (id) begin
         req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = c;
      end else begin
         req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = c;
      end
      for (int k = 0; k < 100 && !got; k++) begin
         @(negedge clk);
         got = id ? req1_ready : req0_ready;
         @(posedge clk);
         #1;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      if (!got) chk("accept_timeout", got, 1);
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int k = 0; k < 300 && !done; k++) begin
         @(posedge clk);
         #1;
         done = !m_act && !busy;
      end
      if (!done) chk("idle_timeout", done, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]   g;
      int           n0;
      bit           got;
      bit           id1;
      logic         a1, b1, c1;
      exp1_t        e1;
      logic [W-1:0] held_sum;

      rst = 1'b1;
      req0_valid = 0; req0_a = '0; req0_b = '0; req0_cin = 0;
      req1_valid = 0; req1_a = '0; req1_b = '0; req1_cin = 0;
      rsp_ready = 1'b1;
      s_req0_valid = 0; s_req0_a = 0; s_req0_b = 0; s_req0_cin = 0;
      s_req1_valid = 0; s_req1_a = 0; s_req1_b = 0; s_req1_cin = 0;
      s_rsp_ready = 1'b1;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset_rsp", {rsp_valid, rsp_cout, rsp_id, rsp_sum}, 0);
      chk("reset_busy_ready", {busy, req0_ready, req1_ready}, 0);
      chk("reset_fa", {fa_a, fa_b, fa_cin}, 0);
      chk("reset_w1_outputs", {s_busy, s_rsp_valid, s_rsp_sum, s_fa_a, s_fa_b, s_fa_cin}, 0);
      rst = 1'b0;

      // directed vectors
      issue(0, 8'h5A, 8'h3C, 1'b0);
      wait_idle();
      chk("v1_sum", last_sum, 8'h96);
      chk("v1_cout_id", {last_cout, last_id}, 2'b00);

      issue(1, 8'hFF, 8'h01, 1'b0);
      wait_idle();
      chk("v2_sum", last_sum, 8'h00);
      chk("v2_cout_id", {last_cout, last_id}, 2'b11);

      issue(1, 8'hFF, 8'hFF, 1'b1);
      wait_idle();
      chk("v3_sum", last_sum, 8'hFF);
      chk("v3_cout_id", {last_cout, last_id}, 2'b11);

      // both requesters held valid from reset: grants must alternate starting at req0
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      grants.delete();
      req0_valid = 1; req0_a = 8'h11; req0_b = 8'h22; req0_cin = 0;
      req1_valid = 1; req1_a = 8'h80; req1_b = 8'h80; req1_cin = 1;
      for (int k = 0; k < 200 && grants.size() < 4; k++) begin
         @(posedge clk);
         #1;
      end
      req0_valid = 0;
      req1_valid = 0;
      for (int k = 0; k < 4; k++) g[k] = (k < grants.size()) ? grants[k] : 1'bx;
      chk("grant_sequence", g, 4'b1010);
      wait_idle();

      // response back-pressure: outputs frozen while rsp_ready is low
      rsp_ready = 1'b0;
      issue(0, 8'h12, 8'h34, 1'b1);
      got = 1'b0;
      for (int k = 0; k < 30 && !got; k++) begin
         @(posedge clk);
         #1;
         got = rsp_valid;
      end
      chk("bp_reach_done", got, 1);
      req1_valid = 1; req1_a = 8'h01; req1_b = 8'h02; req1_cin = 0;
      held_sum = 8'h47;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         chk("bp_sum_stable", rsp_sum, held_sum);
         chk("bp_valid_cout_id", {rsp_valid, rsp_cout, rsp_id}, 3'b100);
         chk("bp_busy", busy, 1);
         chk("bp_ready_zero", {req0_ready, req1_ready}, 0);
         chk("bp_fa_zero", {fa_a, fa_b, fa_cin}, 0);
      end
      rsp_ready  = 1'b1;
      req1_valid = 1'b0;
      wait_idle();

      // reset in the middle of RUN aborts the op with no response
      n0 = n_rsp;
      issue(0, 8'hA5, 8'h5A, 1'b1);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("abort_rsp_zero", {rsp_valid, rsp_cout, rsp_id, rsp_sum}, 0);
      chk("abort_busy_fa", {busy, fa_a, fa_b, fa_cin}, 0);
      chk("abort_ready_zero", {req0_ready, req1_ready}, 0);
      repeat (12) @(posedge clk);
      #1;
      chk("abort_no_response", n_rsp - n0, 0);
      issue(1, 8'h10, 8'h20, 1'b0);
      wait_idle();
      chk("after_abort_id", last_id, 1);
      chk("after_abort_sum", {last_cout, last_sum}, 9'h030);

      // random traffic on the 8-bit instance
      n0 = n_rsp;
      for (int k = 0; k < 7000; k++) begin
         @(posedge clk);
         #1;
         req0_valid = $urandom_range(0, 1); req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = $urandom_range(0, 1);
         req1_valid = $urandom_range(0, 1); req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = $urandom_range(0, 1);
         rsp_ready  = ($urandom_range(0, 3) != 0);
      end
      req0_valid = 0;
      req1_valid = 0;
      rsp_ready  = 1;
      wait_idle();
      chk("rand8_enough_ops", (n_rsp - n0) >= 400, 1);

      // random ops on the 1-bit instance
      for (int k = 0; k < 400; k++) begin
         @(posedge clk);
         #1;
         id1 = $urandom_range(0, 1);
         a1  = $urandom_range(0, 1);
         b1  = $urandom_range(0, 1);
         c1  = $urandom_range(0, 1);
         if (id1) begin
            s_req1_valid = 1; s_req1_a = a1; s_req1_b = b1; s_req1_cin = c1;
         end else begin
            s_req0_valid = 1; s_req0_a = a1; s_req0_b = b1; s_req0_cin = c1;
         end
         @(negedge clk);
         chk("w1_ready", {s_req1_ready, s_req0_ready}, id1 ? 2'b10 : 2'b01);
         sb1.push_back('{id: id1, cout: (a1 & b1) | (a1 & c1) | (b1 & c1), sum: a1 ^ b1 ^ c1});
         @(posedge clk);
         #1;
         s_req0_valid = 0;
         s_req1_valid = 0;
         @(negedge clk);
         chk("w1_fa_bits", {s_fa_a, s_fa_b, s_fa_cin}, {a1, b1, c1});
         chk("w1_run_status", {s_busy, s_rsp_valid}, 2'b10);
         @(negedge clk);
         chk("w1_rsp_valid", s_rsp_valid, 1);
         if (sb1.size() > 0) begin
            e1 = sb1.pop_front();
            chk("w1_result", {s_rsp_id, s_rsp_cout, s_rsp_sum}, e1);
         end
      end
      @(posedge clk);
      #1;
      chk("w1_final_idle", {s_busy, s_rsp_valid}, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
